// File: rtl/alarm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// alarm_bus_arbiter
//
// Purpose: arbitrates one shared tristate alarm-data bus between NREQ room
// alarm stations. Exactly zero or one tristate enable is active at a time.
// Urgent (code-blue) requests beat normal ones. Requests of equal class are
// served round-robin. Each grant owns the bus for HOLD_CYCLES cycles and is
// followed by one guard cycle, so two drivers never overlap.
//
// Handshake: req[i] is a level request held by station i until done[i]
// pulses (its last drive cycle) or until it drops req[i] early (abort).
// en[i] is the registered tristate enable. The display samples the bus
// whenever bus_valid is high.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req        per-station bus request (level)
//   urgent     per-station priority flag, ignored unless req[i] is also set
//   en         one-hot-or-zero tristate enables (registered)
//   grant_id   index of the current owner, meaningful while bus_valid=1
//   bus_valid  high while an enable is high
//   done       one-cycle pulse on the owner's final drive cycle
//   busy       high in GRANT and GUARD
// -----------------------------------------------------------------------------
module alarm_bus_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] urgent,
  output logic [NREQ-1:0] en,
  output logic [IDW-1:0]  grant_id,
  output logic            bus_valid,
  output logic [NREQ-1:0] done,
  output logic            busy
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_grant_id;
  logic [NREQ-1:0] r_en;
  logic            r_bus_valid;
  logic            r_busy;

  logic [NREQ-1:0] w_urg;
  logic [NREQ-1:0] w_pool;
  logic            w_found;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_win_next;

  // Winner search: when any qualified urgent request exists, only urgent
  // stations are candidates. Scan starts at the round-robin pointer and
  // wraps; the first candidate found wins.
  always_comb begin
    w_urg      = req & urgent;
    w_pool     = (w_urg != '0) ? w_urg : req;
    w_found    = 1'b0;
    w_idx      = '0;
    w_win      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && w_pool[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_win_next = IDW'((int'(w_win) + 1) % NREQ);
  end

  // Single FSM. Arbitration happens in IDLE and GUARD; GRANT only counts
  // down or ends early on abort, so nothing can pre-empt an active owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_en        <= '0;
      r_bus_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_GUARD: begin
          if (w_found) begin
            r_state     <= S_GRANT;
            r_en        <= NREQ'(1) << w_win;
            r_grant_id  <= w_win;
            r_bus_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_cnt       <= CW'(HOLD_CYCLES - 1);
            r_rr_ptr    <= w_win_next;
          end else begin
            r_state     <= S_IDLE;
            r_en        <= '0;
            r_bus_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        S_GRANT: begin
          // Abort and normal end of window both release the bus into GUARD.
          if (!req[r_grant_id] || (r_cnt == '0)) begin
            r_state     <= S_GUARD;
            r_en        <= '0;
            r_bus_valid <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_en        <= '0;
          r_bus_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // r_en holds only the owner's bit, so masking with req yields the owner's
  // done bit exactly when it still requests on its last drive cycle.
  assign done      = ((r_state == S_GRANT) && (r_cnt == '0)) ? (r_en & req) : '0;
  assign en        = r_en;
  assign grant_id  = r_grant_id;
  assign bus_valid = r_bus_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alarm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alarm_bus_arbiter
//
// Bench for alarm_bus_arbiter with NREQ=4 and HOLD_CYCLES=4. Each table row
// holds the inputs applied for one clock and the outputs expected right after
// that clock edge. Expected values are pushed to exp_q when the row is driven
// and popped when the outputs are sampled. Reset behaviour is exercised by
// a hand-written sequence. Bus invariants are checked on every falling edge.
// -----------------------------------------------------------------------------
module tb_alarm_bus_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam int W    = 12;  // {busy, bus_valid, grant_id[1:0], en[3:0], done[3:0]}

  // ---------------- clock / reset ----------------
  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] urgent;
  logic [NREQ-1:0] en;
  logic [1:0]      grant_id;
  logic            bus_valid;
  logic [NREQ-1:0] done;
  logic            busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alarm_bus_arbiter #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .urgent    (urgent),
    .en        (en),
    .grant_id  (grant_id),
    .bus_valid (bus_valid),
    .done      (done),
    .busy      (busy)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] urg;
    logic [3:0] en;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             n_tests;
  int             n_fail;
  logic           inv_on;

  function automatic logic [1:0] idx_of(input logic [3:0] e);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (e[i]) r = 2'(i);
    return r;
  endfunction

  task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] u,
                     input logic [3:0] e, input logic [3:0] d, input logic b);
    vec_t v;
    v.rst  = rst;
    v.req  = r;
    v.urg  = u;
    v.en   = e;
    v.done = d;
    v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    req    = '0;
    urgent = '0;
    reset  = 1'b1;
    #3;
    reset  = 1'b0;
  endtask

  task automatic run_vec(input int i);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (vecs[i].rst) do_reset();
    else @(negedge clk);
    req    = vecs[i].req;
    urgent = vecs[i].urg;
    exp_q.push_back({vecs[i].busy, (vecs[i].en != 4'b0),
                     (vecs[i].en != 4'b0) ? idx_of(vecs[i].en) : 2'b00,
                     vecs[i].en, vecs[i].done});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    act_v = {busy, bus_valid, exp_v[10] ? grant_id : 2'b00, en, done};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL vec %0d: got busy=%b bv=%b gid=%0d en=%b done=%b, want busy=%b bv=%b gid=%0d en=%b done=%b",
               i, act_v[11], act_v[10], act_v[9:8], act_v[7:4], act_v[3:0],
               exp_v[11], exp_v[10], exp_v[9:8], exp_v[7:4], exp_v[3:0]);
    end
  endtask

  // ---------------- invariant monitor ----------------
  always @(negedge clk) begin
    if (inv_on) begin
      n_tests++;
      if (($countones(en) > 1) || ((en != 4'b0) !== bus_valid) ||
          ((en != 4'b0) && (en !== (4'b0001 << grant_id)))) begin
        n_fail++;
        $display("FAIL invariant @%0t: en=%b bus_valid=%b grant_id=%0d", $time, en, bus_valid, grant_id);
      end
    end
  end

  // ---------------- stimulus tables ----------------
  task automatic build_table();
    logic [3:0] e;
    // Single request on station 2: four drive cycles, done on the fourth,
    // one guard cycle, then back to idle.
    add(1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1);
    add(0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    // Round-robin with all four requesting: owners 0,1,2,3,0.
    for (int o = 0; o < 5; o++) begin
      e = 4'b0001 << (o % 4);
      for (int c = 0; c < HOLD; c++)
        add((o == 0) && (c == 0), 4'b1111, 4'b0000, e, (c == HOLD - 1) ? e : 4'b0000, 1);
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1);
    end
    // Urgent station 3 wins from rr_ptr=0, then 0, then 1.
    add(1, 4'b1011, 4'b1000, 4'b1000, 4'b0000, 1);
    add(0, 4'b1011, 4'b0000, 4'b1000, 4'b0000, 1);
    add(0, 4'b1011, 4'b0000, 4'b1000, 4'b0000, 1);
    add(0, 4'b1011, 4'b0000, 4'b1000, 4'b1000, 1);
    add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 1);
    add(0, 4'b1011, 4'b0000, 4'b0001, 4'b0000, 1);
    add(0, 4'b1011, 4'b0000, 4'b0001, 4'b0000, 1);
    add(0, 4'b1011, 4'b0000, 4'b0001, 4'b0000, 1);
    add(0, 4'b1011, 4'b0000, 4'b0001, 4'b0001, 1);
    add(0, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 1);
    add(0, 4'b1011, 4'b0000, 4'b0010, 4'b0000, 1);
    // Abort: station 1 drops after two drive cycles; no done pulse. With
    // rr_ptr=2, station 2 beats the re-requesting station 1.
    add(1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1);
    add(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1);
    add(0, 4'b0110, 4'b0000, 4'b0100, 4'b0000, 1);
    // Non-preemption: urgent station 2 arrives while station 0 owns the bus.
    add(1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1);
    add(0, 4'b0101, 4'b0100, 4'b0001, 4'b0000, 1);
    add(0, 4'b0101, 4'b0100, 4'b0001, 4'b0000, 1);
    add(0, 4'b0101, 4'b0100, 4'b0001, 4'b0001, 1);
    add(0, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 1);
    add(0, 4'b0101, 4'b0100, 4'b0100, 4'b0000, 1);
    // Sole requester is re-granted after the guard cycle; a stray urgent bit
    // on a non-requesting station changes nothing.
    add(1, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 1);
    add(0, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 1);
    add(0, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 1);
    add(0, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    inv_on  = 1'b0;
    reset   = 1'b1;
    req     = '0;
    urgent  = '0;
    build_table();
    #12;
    check("reset_en",        32'(en),        32'h0);
    check("reset_bus_valid", 32'(bus_valid), 32'h0);
    check("reset_busy",      32'(busy),      32'h0);
    check("reset_grant_id",  32'(grant_id),  32'h0);
    check("reset_done",      32'(done),      32'h0);
    reset  = 1'b0;
    inv_on = 1'b1;

    // Reset asserted mid-grant must drop the enable before the next edge.
    @(negedge clk);
    req = 4'b0010;
    @(posedge clk);
    #1;
    check("pre_reset_en", 32'(en), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_en",        32'(en),        32'h0);
    check("async_reset_bus_valid", 32'(bus_valid), 32'h0);
    check("async_reset_busy",      32'(busy),      32'h0);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0001;
    @(posedge clk);
    #1;
    check("post_reset_en",       32'(en),       32'h1);
    check("post_reset_grant_id", 32'(grant_id), 32'h0);

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    @(negedge clk);
    inv_on = 1'b0;
    req    = '0;
    urgent = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_bus_arbiter.md
Name: alarm_bus_arbiter

Overview:
Arbitrates one shared N-bit tristate alarm-data bus between NREQ requester stations (room alarm units). The block drives one enable per station's tristate buffer, so at most one driver is active at any time. It sits between the station request logic and the central display/decoder that samples the bus. Urgent (code-blue) requests beat normal requests; requests of equal class are served round-robin. Every grant holds the bus for a fixed window, then inserts a guard cycle to prevent driver overlap.

Parameters:
NREQ, 4, number of requesting stations; legal range 2..8
HOLD_CYCLES, 4, clock cycles each granted station drives the bus; must be >= 1
IDW, $clog2(NREQ), width of grant_id (derived; do not override)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-station bus request; level, held until done or abort
urgent  input  NREQ  per-station priority flag; qualified by req[i]
en  output  NREQ  one-hot-or-zero tristate buffer enables, registered
grant_id  output  IDW  index of the current owner; valid only while bus_valid=1
bus_valid  output  1  high while some en bit is high; the display samples the bus when high
done  output  NREQ  one-cycle pulse on the station's last drive cycle of a full window
busy  output  1  high in GRANT and GUARD states

Behaviour:
- Reset (async, immediate): en=0, done=0, bus_valid=0, busy=0, grant_id=0, rr_ptr=0, state=IDLE, hold counter=0. Reset asserted mid-grant drops en in the same instant, without waiting for a clock edge.
- States: IDLE, GRANT, GUARD.
- Arbitration runs in IDLE and GUARD and evaluates req/urgent on the clock edge.
- Winner selection:
  - If any req[i]&urgent[i] is set, search only urgent requesters. Otherwise search all requesters.
  - Search order is rr_ptr, rr_ptr+1, ... with wrap modulo NREQ. The first hit wins.
- IDLE -> GRANT when any req bit is set. On that edge: en[w]=1, grant_id=w, bus_valid=1, busy=1, counter=HOLD_CYCLES-1, rr_ptr=(w+1) mod NREQ.
- Latency: a request seen at edge k produces en high after edge k (one-cycle registered latency).
- GRANT, per edge:
  - If req[w]=0 (abort): go to GUARD. en=0, bus_valid=0, no done pulse.
  - Else if counter=0: go to GUARD. en=0, bus_valid=0.
  - Else decrement the counter.
  - The owner drives for exactly HOLD_CYCLES cycles unless it aborts.
- done[w] is high during the final drive cycle (counter=0, req[w]=1). It is combinational from registered state and never high outside GRANT.
- Requests from other stations, including urgent ones, never pre-empt an active grant.
- GUARD lasts exactly one cycle with en=0. On its exit edge, either grant the new winner directly (GRANT) or go to IDLE if req=0. Minimum bus-idle gap between two owners is 1 cycle.
- rr_ptr updates only on a grant. An abort still advances it.
- A station whose req stays high after done re-enters arbitration in GUARD. rr_ptr already excludes it unless it is the only requester; a sole requester is re-granted after the guard cycle.
- Invariants:
  - popcount(en) <= 1 always.
  - en != 0 iff bus_valid.
  - grant_id equals the index of the set en bit.
- Urgent bits without a matching req bit are ignored.

Test Plan:
- Reset: assert reset mid-GRANT (en=0010) -> en=0000, bus_valid=0 before the next clk edge. After release, req=0001 -> en=0001 one edge later.
- Single request: req=0100, HOLD_CYCLES=4 -> en=0100 for 4 cycles, done[2] high on the 4th, then 1 guard cycle of en=0, then IDLE.
- Round-robin: req=1111 held, no urgent -> grants in order 0,1,2,3,0, each 4 drive cycles with a 1-cycle gap; grant_id tracks each owner.
- Urgent priority: rr_ptr=0, req=1011, urgent=1000 -> station 3 granted first, then 0, 1 (with urgent cleared).
- Abort: station 1 granted, req[1] dropped after 2 drive cycles -> en=0 next edge, no done pulse, guard cycle, next requester granted; rr_ptr=2.
- Non-preemption: station 0 holding the bus, urgent req on station 2 arrives mid-window -> station 0 completes all 4 cycles, then station 2 is granted after the guard cycle; en never has 2 bits set.
